// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: push-button debounce with a shared sample tick,
// fixed-priority press arbitration and a small FWFT event queue.
//
// Ports:
//   clk_100MHz  system clock (rising edge)
//   rst_n       asynchronous active-low reset
//   btn_raw     raw asynchronous button inputs, 1 = pressed
//   btn_level   debounced stable level per button
//   evt_valid   queue non-empty, evt_id valid
//   evt_id      index of the oldest queued press
//   evt_ready   consumer pops head when evt_valid & evt_ready
//   evt_lost    1-cycle pulse when a press is dropped
//   tick        1-cycle shared sample strobe
module btn_event_ctrl #(
    parameter int N_BTN       = 5,
    parameter int TICK_CYCLES = 2000000,
    parameter int FIFO_DEPTH  = 4,
    localparam int ID_W       = $clog2(N_BTN),
    localparam int CNT_W      = $clog2(TICK_CYCLES)
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic             evt_lost,
    output logic             tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] samp;
    logic [N_BTN-1:0] pend;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [ID_W-1:0]  mem [FIFO_DEPTH];

    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic [ID_W-1:0]  grant_id;
    logic [N_BTN-1:0] grant;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] rise;
    logic             lost_nxt;

    assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign evt_valid = ~empty;
    assign evt_id    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop       = evt_valid & evt_ready;

    // A bit is accepted only when two consecutive tick samples agree.
    always_comb begin
        level_nxt = btn_level;
        if (tick) begin
            level_nxt = (sync & ~(sync ^ samp)) |
                        (btn_level & (sync ^ samp));
        end
        rise = level_nxt & ~btn_level;
    end

    // Lowest pending index wins; no grant while the queue is full.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        push     = 1'b0;
        if (!full) begin
            for (int i = N_BTN - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    grant_id = ID_W'(i);
                    push     = 1'b1;
                end
            end
        end
    end

    // A new press on a bit that is still pending and not granted is lost.
    assign lost_nxt = |(rise & pend & ~grant);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync      <= '0;
            samp      <= '0;
            btn_level <= '0;
            pend      <= '0;
            cnt       <= '0;
            evt_lost  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sync_q1 <= btn_raw;
            sync    <= sync_q1;

            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (tick) begin
                samp      <= sync;
                btn_level <= level_nxt;
            end

            // Set wins over a same-cycle grant clear.
            pend     <= (pend & ~grant) | rise;
            evt_lost <= lost_nxt;

            if (push) begin
                mem[wr_ptr[AW-1:0]] <= grant_id;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed and randomized checks of btn_event_ctrl
// against a queue-based behavioural model.
module tb_btn_event_ctrl;

    localparam int N     = 5;
    localparam int TICK  = 8;
    localparam int DEPTH = 4;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_ready;
    logic       evt_lost;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [4:0] m_d1, m_d2, m_samp, m_level, m_pend;
    logic       m_lost;
    int         m_k;
    int         m_q[$];

    always #5 clk_100MHz = ~clk_100MHz;

    btn_event_ctrl #(
        .N_BTN       (N),
        .TICK_CYCLES (TICK),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .evt_lost   (evt_lost),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_d1 = '0; m_d2 = '0; m_samp = '0; m_level = '0;
        m_pend = '0; m_lost = 1'b0; m_k = 0;
        m_q.delete();
    endtask

    task automatic check_outputs();
        logic [7:0] exp_id;
        exp_id = (m_q.size() != 0) ? 8'(m_q[0]) : 8'd0;
        check("level", 8'(btn_level), 8'(m_level));
        check("valid", 8'(evt_valid), 8'(m_q.size() != 0));
        check("id", 8'(evt_id), exp_id);
        check("lost", 8'(evt_lost), 8'(m_lost));
        check("tick", 8'(tick), 8'((m_k % TICK) == TICK - 1));
    endtask

    // One clock: predict from the spec rules, advance, compare.
    task automatic cycle();
        logic [4:0] sv, nl, ns, rise, clr, raw_v;
        logic       tk, nlost, dpop, dpush, run_m;
        int         pid;
        run_m = rst_n;
        raw_v = btn_raw;
        sv    = m_d2;
        tk    = (m_k % TICK) == TICK - 1;
        nl    = m_level;
        ns    = m_samp;
        if (tk) begin
            for (int i = 0; i < N; i++) begin
                if (sv[i] == m_samp[i]) nl[i] = sv[i];
            end
            ns = sv;
        end
        rise  = nl & ~m_level;
        clr   = '0;
        dpush = 1'b0;
        pid   = 0;
        if (m_q.size() < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && !dpush) begin
                    pid   = i;
                    dpush = 1'b1;
                end
            end
            if (dpush) clr[pid] = 1'b1;
        end
        nlost = |(rise & m_pend & ~clr);
        dpop  = (m_q.size() != 0) && evt_ready;
        @(posedge clk_100MHz);
        #1;
        if (!run_m) begin
            m_reset();
        end else begin
            if (dpop) void'(m_q.pop_front());
            if (dpush) m_q.push_back(pid);
            m_pend  = (m_pend & ~clr) | rise;
            m_level = nl;
            m_samp  = ns;
            m_lost  = nlost;
            m_d2    = m_d1;
            m_d1    = raw_v;
            m_k     = m_k + 1;
        end
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_level(input int b, output logic ok);
        int n;
        n = 0;
        while (!btn_level[b] && n < 60) begin
            cycle();
            n++;
        end
        ok = btn_level[b];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int   n, lost_cnt, d3;
        rst_n     = 1'b0;
        btn_raw   = '0;
        evt_ready = 1'b0;
        m_reset();
        run(2);

        // reset mid-operation with all buttons pressed
        rst_n   = 1'b1;
        btn_raw = 5'h1F;
        run(20);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_level", 8'(btn_level), 8'h00);
        check("rst_valid", 8'(evt_valid), 8'h00);
        check("rst_id", 8'(evt_id), 8'h00);
        check("rst_lost", 8'(evt_lost), 8'h00);
        check("rst_tick", 8'(tick), 8'h00);
        m_reset();
        cycle();
        rst_n = 1'b1;
        n = 0;
        while (btn_level == 0 && n < 40) begin
            cycle();
            n++;
        end
        check("rel_latency", 8'(n), 8'd16);
        check("rel_level", 8'(btn_level), 8'h1F);
        btn_raw   = '0;
        evt_ready = 1'b1;
        run(50);

        // single press
        evt_ready  = 1'b0;
        btn_raw[2] = 1'b1;
        wait_level(2, ok);
        check("s2_wait", 8'(ok), 8'd1);
        cycle();
        check("s2_valid", 8'(evt_valid), 8'd1);
        check("s2_id", 8'(evt_id), 8'd2);
        evt_ready = 1'b1;
        cycle();
        check("s2_pop", 8'(evt_valid), 8'd0);
        btn_raw = '0;
        run(40);

        // bounce on button 0
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_raw[0] = ~btn_raw[0];
            cycle();
        end
        btn_raw = '0;
        run(40);

        // simultaneous press, priority order
        btn_raw = 5'b10010;
        wait_level(1, ok);
        check("s4_wait", 8'(ok), 8'd1);
        cycle();
        check("s4_v1", 8'(evt_valid), 8'd1);
        check("s4_id1", 8'(evt_id), 8'd1);
        cycle();
        check("s4_v4", 8'(evt_valid), 8'd1);
        check("s4_id4", 8'(evt_id), 8'd4);
        cycle();
        check("s4_empty", 8'(evt_valid), 8'd0);
        btn_raw = '0;
        run(40);
        check("s4_release", 8'(evt_valid), 8'd0);

        // full queue with back-pressure
        evt_ready = 1'b0;
        for (int b = 0; b < N; b++) begin
            btn_raw[b] = 1'b1;
            run(20);
        end
        run(20);
        evt_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("s5_valid", 8'(evt_valid), 8'd1);
            check("s5_id", 8'(evt_id), 8'(i));
            cycle();
        end
        evt_ready = 1'b0;
        check("s5_empty", 8'(evt_valid), 8'd0);
        btn_raw = '0;
        run(40);

        // dropped press on a pending button
        btn_raw = 5'b10111;
        run(40);
        btn_raw[3] = 1'b1;
        run(30);
        lost_cnt   = 0;
        btn_raw[3] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (evt_lost) lost_cnt++;
        end
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (evt_lost) lost_cnt++;
        end
        check("s6_lost", 8'(lost_cnt), 8'd1);
        evt_ready = 1'b1;
        d3 = 0;
        for (int i = 0; i < 20; i++) begin
            if (evt_valid && evt_id == 3) d3++;
            cycle();
        end
        check("s6_id3", 8'(d3), 8'd1);
        btn_raw = '0;
        run(40);

        // randomized traffic
        for (int s = 0; s < 40; s++) begin
            btn_raw   = 5'($urandom);
            evt_ready = ($urandom % 3) == 0;
            run($urandom_range(1, 30));
        end
        btn_raw   = '0;
        evt_ready = 1'b1;
        run(60);
        check("final_empty", 8'(evt_valid), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
